// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 compression control slice.
package sha256_pkg;

  localparam int SHA256_ROUNDS      = 64;
  localparam int SHA256_SCHED_WORDS = 16;
  localparam int SHA256_WORD_W      = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } sha256_ctrl_state_t;

endpackage

// File: rtl/sha256_round_counter.sv
// Round index counter: clears on rst or clr, advances on en, flags the last round.
module sha256_round_counter #(
  parameter int ROUNDS = 64,
  parameter int CW     = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          last
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign last = (count == CW'(ROUNDS - 1));

endmodule

// File: rtl/sha256_round_ctrl.sv
// Sequences init, ROUNDS compression rounds and the hash update for one accepted block.
// Outputs decode registered state; only reg_en_o during rounds follows stall_i combinationally.
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int ROUNDS = SHA256_ROUNDS,
  parameter int CW     = 6
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          blk_valid_i,
  input  logic          first_i,
  input  logic          stall_i,
  output logic          blk_ready_o,
  output logic          init_o,
  output logic          iv_sel_o,
  output logic          reg_en_o,
  output logic [CW-1:0] round_o,
  output logic          w_sel_o,
  output logic          hash_upd_o,
  output logic          busy_o,
  output logic          done_o
);

  sha256_ctrl_state_t state, state_nxt;
  logic [CW-1:0]      round_q;
  logic               round_last;
  logic               cnt_en;
  logic               cnt_clr;
  logic               accept;

  sha256_round_counter #(
    .ROUNDS(ROUNDS),
    .CW    (CW)
  ) u_cnt (
    .clk  (CLK),
    .rst  (RST),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .count(round_q),
    .last (round_last)
  );

  assign accept = blk_valid_i & blk_ready_o;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Init source is latched per block so it stays stable across the whole compression.
  always_ff @(posedge CLK) begin
    if (RST) begin
      iv_sel_o <= 1'b0;
    end else if (accept) begin
      iv_sel_o <= first_i;
    end
  end

  always_comb begin
    state_nxt   = state;
    blk_ready_o = 1'b0;
    init_o      = 1'b0;
    reg_en_o    = 1'b0;
    w_sel_o     = 1'b0;
    hash_upd_o  = 1'b0;
    done_o      = 1'b0;
    cnt_en      = 1'b0;
    cnt_clr     = 1'b0;
    case (state)
      ST_IDLE: begin
        blk_ready_o = 1'b1;
        if (blk_valid_i) state_nxt = ST_INIT;
      end
      ST_INIT: begin
        init_o    = 1'b1;
        reg_en_o  = 1'b1;
        state_nxt = ST_ROUND;
      end
      ST_ROUND: begin
        reg_en_o = ~stall_i;
        w_sel_o  = (round_q < CW'(SHA256_SCHED_WORDS));
        if (!stall_i) begin
          cnt_en = 1'b1;
          if (round_last) begin
            cnt_clr   = 1'b1;
            state_nxt = ST_FINAL;
          end
        end
      end
      ST_FINAL: begin
        hash_upd_o = 1'b1;
        state_nxt  = ST_DONE;
      end
      ST_DONE: begin
        done_o    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy_o  = (state != ST_IDLE);
  assign round_o = round_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench: a block-position model checked every cycle plus literal latency pins.
module tb_sha256_round_ctrl;

  localparam int ROUNDS = 64;
  localparam int CW     = 6;

  logic          CLK = 1'b0;
  logic          RST;
  logic          blk_valid_i;
  logic          first_i;
  logic          stall_i;
  logic          blk_ready_o;
  logic          init_o;
  logic          iv_sel_o;
  logic          reg_en_o;
  logic [CW-1:0] round_o;
  logic          w_sel_o;
  logic          hash_upd_o;
  logic          busy_o;
  logic          done_o;

  sha256_round_ctrl #(.ROUNDS(ROUNDS), .CW(CW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .blk_valid_i(blk_valid_i),
    .first_i    (first_i),
    .stall_i    (stall_i),
    .blk_ready_o(blk_ready_o),
    .init_o     (init_o),
    .iv_sel_o   (iv_sel_o),
    .reg_en_o   (reg_en_o),
    .round_o    (round_o),
    .w_sel_o    (w_sel_o),
    .hash_upd_o (hash_upd_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: pos is the block's position in its timeline.
  // 0 idle, 1 init, 2..ROUNDS+1 round pos-2, ROUNDS+2 final, ROUNDS+3 done.
  int pos   = 0;
  bit m_iv  = 0;
  bit armed = 0;
  int cyc   = 0;

  function automatic bit in_round(input int p);
    return (p >= 2) && (p <= ROUNDS + 1);
  endfunction

  always @(posedge CLK) begin
    cyc++;
    if (RST) begin
      pos   = 0;
      m_iv  = 0;
      armed = 1;
    end else if (pos == 0) begin
      if (blk_valid_i) begin
        pos  = 1;
        m_iv = first_i;
      end
    end else if (in_round(pos) && stall_i) begin
      pos = pos;
    end else if (pos == ROUNDS + 3) begin
      pos = 0;
    end else begin
      pos++;
    end
  end

  int init_cyc = 0, done_cyc = 0, init_iv = 0;
  int hash_cnt = 0, done_cnt = 0, wsel_cnt = 0;

  always @(negedge CLK) begin
    if (armed) begin
      chk("blk_ready", blk_ready_o, pos == 0);
      chk("init",      init_o,      pos == 1);
      chk("iv_sel",    iv_sel_o,    m_iv);
      chk("reg_en",    reg_en_o,    (pos == 1) || (in_round(pos) && !stall_i));
      chk("round",     round_o,     in_round(pos) ? pos - 2 : 0);
      chk("w_sel",     w_sel_o,     in_round(pos) && (pos - 2 < 16));
      chk("hash_upd",  hash_upd_o,  pos == ROUNDS + 2);
      chk("busy",      busy_o,      pos != 0);
      chk("done",      done_o,      pos == ROUNDS + 3);
      if (init_o === 1'b1) begin
        init_cyc = cyc;
        init_iv  = iv_sel_o;
        wsel_cnt = 0;
      end
      if (w_sel_o === 1'b1) wsel_cnt++;
      if (hash_upd_o === 1'b1) hash_cnt++;
      if (done_o === 1'b1) begin
        done_cyc = cyc;
        done_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait expired, expected event did not occur", name);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 200; i++) begin
      step();
      if (done_o === 1'b1) return;
    end
    timeout(name);
  endtask

  task automatic wait_round(input int r, input string name);
    for (int i = 0; i < 200; i++) begin
      step();
      if (busy_o === 1'b1 && init_o === 1'b0 && round_o == CW'(r)) return;
    end
    timeout(name);
  endtask

  int hc, dc, d1;

  initial begin
    RST = 1'b1; blk_valid_i = 1'b0; first_i = 1'b0; stall_i = 1'b0;

    // Reset then idle; stall is meaningless while idle.
    step(); step();
    RST = 1'b0;
    stall_i = 1'b1;
    step(); step();
    stall_i = 1'b0;
    step();
    chk("idle_ready", blk_ready_o, 1);
    chk("idle_busy",  busy_o,      0);

    // Single block from IV, no stalls.
    blk_valid_i = 1'b1; first_i = 1'b1;
    step();
    blk_valid_i = 1'b0; first_i = 1'b0;
    chk("b1_init_now", init_o, 1);
    step();
    chk("b1_round0", round_o, 0);
    wait_done("b1_done");
    step();
    chk("b1_latency",    done_cyc - init_cyc, 66);
    chk("b1_iv_at_init", init_iv,  1);
    chk("b1_wsel_count", wsel_cnt, 16);
    chk("b1_done_pulse", done_o,   0);
    chk("b1_ready_back", blk_ready_o, 1);

    // Stalls: 3 cycles at round 20, 1 cycle at the last round.
    blk_valid_i = 1'b1; first_i = 1'b0;
    step();
    blk_valid_i = 1'b0;
    wait_round(20, "stall_r20");
    stall_i = 1'b1;
    step(); step(); step();
    chk("stall_frozen", round_o, 20);
    stall_i = 1'b0;
    wait_round(63, "stall_r63");
    stall_i = 1'b1;
    step();
    chk("stall_last_hold", hash_upd_o, 0);
    stall_i = 1'b0;
    wait_done("stall_done");
    step();
    chk("stall_latency", done_cyc - init_cyc, 70);
    chk("stall_iv",      init_iv, 0);

    // Two back-to-back blocks with valid held high throughout.
    blk_valid_i = 1'b1; first_i = 1'b1;
    step();
    first_i = 1'b0;
    wait_done("bb_done1");
    d1 = cyc;
    step();
    chk("bb_idle_gap", blk_ready_o, 1);
    step();
    blk_valid_i = 1'b0;
    chk("bb_init2",    init_o,   1);
    chk("bb_iv2",      iv_sel_o, 0);
    chk("bb_gap",      cyc - d1, 2);
    wait_done("bb_done2");
    step();
    chk("bb_latency2", done_cyc - init_cyc, 66);

    // Reset in mid-round aborts the block silently.
    blk_valid_i = 1'b1; first_i = 1'b1;
    step();
    blk_valid_i = 1'b0;
    wait_round(30, "abort_r30");
    hc = hash_cnt; dc = done_cnt;
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("abort_round", round_o,     0);
    chk("abort_busy",  busy_o,      0);
    chk("abort_ready", blk_ready_o, 1);
    chk("abort_iv",    iv_sel_o,    0);
    repeat (80) step();
    chk("abort_no_hash", hash_cnt - hc, 0);
    chk("abort_no_done", done_cnt - dc, 0);

    // Reset coincident with a request.
    RST = 1'b1; blk_valid_i = 1'b1; first_i = 1'b1;
    step();
    RST = 1'b0; blk_valid_i = 1'b0; first_i = 1'b0;
    chk("rstacc_init", init_o, 0);
    chk("rstacc_busy", busy_o, 0);
    step();
    chk("rstacc_still_idle", init_o, 0);
    chk("rstacc_iv",         iv_sel_o, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_round_ctrl.md
# sha256_round_ctrl

Sequencing controller for the SHA-256 compression datapath. Accepts one 512-bit block request through a valid/ready handshake, then drives the load enables of the eight 32-bit working registers (A–H) and the message-schedule datapath through init, 64 rounds and the final hash-update cycle. It sits between the message-padding front end and the register/adder datapath, and is the only source of the registers' `start` enables.

## Interface
- `ROUNDS`, 64: compression rounds per block; must be ≥ `SCHED_WORDS` + 1.
- `CW`, 6: round-counter width; must satisfy 2^`CW` ≥ `ROUNDS`.
- `CLK` input 1: single clock; all state updates on the rising edge.
- `RST` input 1: reset; synchronous, active-high.
- `blk_valid_i` input 1: a message block is available on the front end.
- `first_i` input 1: the block is the first of a message; sampled only on acceptance.
- `stall_i` input 1: freezes round progress (schedule memory not ready).
- `blk_ready_o` output 1: the controller can accept a block.
- `init_o` output 1: load A–H from the chaining value or IV; load W[0..15].
- `iv_sel_o` output 1: select IV (1) or the stored hash H0–H7 (0) as the init source.
- `reg_en_o` output 1: `start` enable to working registers A–H.
- `round_o` output `CW`: current round index, for K-constant lookup.
- `w_sel_o` output 1: use the raw block word (1) or the computed schedule word (0).
- `hash_upd_o` output 1: update H0–H7 with H + working registers.
- `busy_o` output 1: the controller is in any state other than IDLE.
- `done_o` output 1: single-cycle pulse; the block digest is valid in H0–H7.

## Operation
- States: IDLE, INIT, ROUND, FINAL, DONE. State encoding comes from the package.
- **IDLE**
  - `blk_ready_o` = 1.
  - Acceptance is `blk_valid_i` & `blk_ready_o` at a clock edge.
  - On acceptance, capture `first_i` into `iv_sel_o` and go to INIT.
  - `stall_i` is ignored in IDLE.
- **INIT** (one cycle)
  - `init_o` = 1, `reg_en_o` = 1, `round_o` = 0.
  - Next state is ROUND. `stall_i` is ignored in INIT.
- **ROUND**
  - `reg_en_o` = ~`stall_i`.
  - `w_sel_o` = (`round_o` < 16).
  - The counter increments only when `stall_i` = 0.
  - At `round_o` = `ROUNDS`-1 with `stall_i` = 0: go to FINAL and reset the counter to 0.
  - While stalled, all outputs hold and `reg_en_o` = 0, so the working registers hold.
- **FINAL** (one cycle)
  - `hash_upd_o` = 1, `reg_en_o` = 0. Next state is DONE.
- **DONE** (one cycle)
  - `done_o` = 1. Next state is IDLE.
  - `blk_ready_o` = 0 in DONE; there are no back-to-back acceptances from DONE.
- `iv_sel_o` holds its captured value from acceptance until the next acceptance.
- `blk_valid_i` and `first_i` are don't-care outside IDLE. A request arriving mid-block is simply not accepted and must be held by the front end.
- Counter arithmetic is unsigned `CW`-bit and never wraps. The terminal compare ends the count at `ROUNDS`-1.

## Timing
- Reset values (`RST` = 1 at an edge):
  - State IDLE, counter 0, `iv_sel_o` = 0.
  - `init_o`, `reg_en_o`, `hash_upd_o`, `done_o`, `busy_o` = 0; `round_o` = 0.
  - `blk_ready_o` = 1 from the first cycle after reset.
- Outputs are Moore, decoded from registered state/counter. `reg_en_o` in ROUND is the only combinational path, from `stall_i`.
- Cycle latency with acceptance at edge T and no stalls:
  - INIT during cycle T+1.
  - Rounds 0..63 during T+2..T+65.
  - FINAL at T+66.
  - `done_o` high at T+67.
  - `blk_ready_o` high again at T+68.
  - Each stall cycle adds one cycle of latency.
- Reset has priority over everything, including mid-ROUND and a simultaneous acceptance. No `done_o` or `hash_upd_o` is produced for an aborted block.
- `stall_i` asserted on the final round delays the FINAL transition until it deasserts.

## Structure
- Shared package `sha256_pkg`:
  - state enum `sha256_ctrl_state_t`;
  - constants `SHA256_ROUNDS` = 64, `SHA256_SCHED_WORDS` = 16, `SHA256_WORD_W` = 32.
- One natural sub-module, `sha256_round_counter`:
  - `CW`-bit counter with `clr`/`en` inputs and a `last` flag at `ROUNDS`-1.
  - Same clock and synchronous reset as the parent.
- The FSM stays in the top module.

## Test plan
- Reset then idle: `RST` high for 2 cycles -> all outputs at their reset values and `blk_ready_o` = 1; with `blk_valid_i` held 0, state stays IDLE.
- Single block, `first_i` = 1, no stalls -> `init_o` at T+1 with `iv_sel_o` = 1; `round_o` runs 0..63 at T+2..T+65; `w_sel_o` = 1 exactly for rounds 0..15; `hash_upd_o` at T+66; `done_o` at T+67 for exactly one cycle.
- Stall injection: `stall_i` high for 3 cycles at round 20 and 1 cycle at round 63 -> `round_o` frozen, `reg_en_o` = 0 during the stalls, `done_o` delayed to T+71.
- Two consecutive blocks, `first_i` = 1 then 0, `blk_valid_i` held high -> the second block is accepted at T+68 with `iv_sel_o` = 0; `blk_valid_i` is ignored during busy.
- Reset mid-operation: `RST` pulsed at round 30 -> the next cycle shows IDLE with `round_o` = 0; no `hash_upd_o` or `done_o` for the aborted block.
- Reset coincident with acceptance: `RST` and `blk_valid_i` high at the same edge -> remains IDLE, no INIT cycle.
